// File: rtl/mem_stage_lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_lsu_if
// Brief    : EX-side request and WB-side result bundle for the MEM stage,
//            plus the debug op counters.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_stage_lsu_if #(
  parameter int XLEN   = 32,
  parameter int RIDX_W = 5
);
  // EX -> MEM request
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic [1:0]        in_size;
  logic              in_unsigned;
  logic [XLEN-1:0]   in_addr;
  logic [XLEN-1:0]   in_wdata;
  logic [XLEN-1:0]   in_alu_result;
  logic [RIDX_W-1:0] in_rd;
  logic              in_rd_we;
  // MEM -> WB result
  logic              out_valid;
  logic              out_ready;
  logic [RIDX_W-1:0] out_rd;
  logic              out_rd_we;
  logic [XLEN-1:0]   out_data;
  logic              out_fault;
  logic [1:0]        out_fault_cause;
  // debug counters
  logic [31:0]       load_count;
  logic [31:0]       store_count;

  // stage side
  modport slave (
    input  in_valid, in_op, in_size, in_unsigned, in_addr, in_wdata,
           in_alu_result, in_rd, in_rd_we, out_ready,
    output in_ready, out_valid, out_rd, out_rd_we, out_data, out_fault,
           out_fault_cause, load_count, store_count
  );

  // pipeline neighbour side (EX producer / WB consumer)
  modport master (
    output in_valid, in_op, in_size, in_unsigned, in_addr, in_wdata,
           in_alu_result, in_rd, in_rd_we, out_ready,
    input  in_ready, out_valid, out_rd, out_rd_we, out_data, out_fault,
           out_fault_cause, load_count, store_count
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_lsu
// Brief    : MEM pipeline stage with integrated byte-lane data RAM. One
//            load/store/pass op per cycle, 1-cycle latency, fault flagging
//            and debug op counters.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_lsu #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 256,
  parameter int RIDX_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_stage_lsu_if.slave        bus
);

  localparam int              AW         = $clog2(DEPTH);
  localparam logic [XLEN-1:0] ADDR_LIMIT = XLEN'(DEPTH * 4);

  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_STORE  = 2'b10;
  localparam logic [1:0] SZ_BYTE   = 2'b00;
  localparam logic [1:0] SZ_HALF   = 2'b01;
  localparam logic [1:0] SZ_WORD   = 2'b10;
  localparam logic [1:0] SZ_ILL    = 2'b11;
  localparam logic [1:0] CZ_NONE   = 2'b00;
  localparam logic [1:0] CZ_ALIGN  = 2'b01;
  localparam logic [1:0] CZ_RANGE  = 2'b10;
  localparam logic [1:0] CZ_SIZE   = 2'b11;

  logic [XLEN-1:0]   mem [DEPTH];

  logic              accept;
  logic              is_load;
  logic              is_store;
  logic              fault;
  logic [1:0]        cause;
  logic [AW-1:0]     widx;
  logic [1:0]        lane;
  logic [RIDX_W-1:0] next_rd;
  logic [XLEN-1:0]   rword;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   load_val;
  logic [XLEN-1:0]   st_data;
  logic [3:0]        st_be;
  logic              st_en;

  // A new op may enter whenever the output register is empty or being drained.
  assign bus.in_ready = !rst && (!bus.out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign is_load      = (bus.in_op == OP_LOAD);
  assign is_store     = (bus.in_op == OP_STORE);
  assign widx         = bus.in_addr[AW+1:2];
  assign lane         = bus.in_addr[1:0];
  assign next_rd      = bus.in_rd;
  assign fault        = (cause != CZ_NONE);
  assign st_en        = accept && is_store && !fault;

  // Fault classification for memory ops, highest priority first.
  always_comb begin
    cause = CZ_NONE;
    if (is_load || is_store) begin
      if (bus.in_size == SZ_ILL)
        cause = CZ_SIZE;
      else if ((bus.in_size == SZ_HALF && bus.in_addr[0]) ||
               (bus.in_size == SZ_WORD && bus.in_addr[1:0] != 2'b00))
        cause = CZ_ALIGN;
      else if (bus.in_addr >= ADDR_LIMIT)
        cause = CZ_RANGE;
    end
  end

  // Select the addressed byte/half/word of the RAM word and extend it.
  always_comb begin
    rword   = mem[widx];
    shifted = rword >> {lane, 3'b000};
    case (bus.in_size)
      SZ_BYTE: load_val = bus.in_unsigned ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                          : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_val = bus.in_unsigned ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                          : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      default: load_val = rword;
    endcase
  end

  // Replicate store data across lanes and enable only the addressed lanes.
  always_comb begin
    st_be   = 4'b1111;
    st_data = bus.in_wdata;
    case (bus.in_size)
      SZ_BYTE: begin
        st_be   = 4'b0001 << lane;
        st_data = {4{bus.in_wdata[7:0]}};
      end
      SZ_HALF: begin
        st_be   = 4'b0011 << lane;
        st_data = {2{bus.in_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Byte-lane RAM write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (st_en) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem[widx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  // Output register: capture on accept, drop on drain, hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid       <= 1'b0;
      bus.out_rd          <= '0;
      bus.out_rd_we       <= 1'b0;
      bus.out_data        <= '0;
      bus.out_fault       <= 1'b0;
      bus.out_fault_cause <= CZ_NONE;
    end else if (accept) begin
      bus.out_valid       <= 1'b1;
      bus.out_rd          <= next_rd;
      bus.out_fault       <= fault;
      bus.out_fault_cause <= cause;
      if (fault || is_store) begin
        bus.out_rd_we <= 1'b0;
        bus.out_data  <= '0;
      end else if (is_load) begin
        bus.out_rd_we <= bus.in_rd_we;
        bus.out_data  <= load_val;
      end else begin
        bus.out_rd_we <= bus.in_rd_we;
        bus.out_data  <= bus.in_alu_result;
      end
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  // Debug counters of accepted, non-faulted memory ops (free-running wrap).
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.load_count  <= '0;
      bus.store_count <= '0;
    end else if (accept && !fault) begin
      if (is_load)  bus.load_count  <= bus.load_count + 32'd1;
      if (is_store) bus.store_count <= bus.store_count + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_lsu
// Brief    : Self-checking bench for mem_stage_lsu: directed scenarios plus
//            randomized traffic against a byte-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_lsu;

  localparam int DEPTH = 256;

  typedef struct packed {
    logic        valid;
    logic [1:0]  op;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        rd_we;
  } stim_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] data;
    logic        fault;
    logic [1:0]  cause;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_stage_lsu_if #(.XLEN(32), .RIDX_W(5)) bus ();

  mem_stage_lsu #(.XLEN(32), .DEPTH(DEPTH), .RIDX_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  mm [DEPTH*4];
  res_t        q [$];
  logic [31:0] m_loads  = 0;
  logic [31:0] m_stores = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one accepted op on a little-endian byte memory.
  task automatic model_exec(input stim_t s, output res_t e);
    int          nb;
    logic [31:0] v;
    e = '0;
    e.rd = s.rd;
    if (s.op == 2'd1 || s.op == 2'd2) begin
      nb = (s.size == 2'd0) ? 1 : (s.size == 2'd1) ? 2 : 4;
      if (s.size == 2'd3)             e.cause = 2'd3;
      else if (s.addr % nb != 0)      e.cause = 2'd1;
      else if (s.addr >= DEPTH * 4)   e.cause = 2'd2;
      if (e.cause != 2'd0) begin
        e.fault = 1'b1;
      end else if (s.op == 2'd1) begin
        v = 0;
        for (int k = 0; k < nb; k++) v = v | (32'(mm[s.addr + k]) << (8 * k));
        if (!s.uns && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
        e.data  = v;
        e.rd_we = s.rd_we;
        m_loads = m_loads + 1;
      end else begin
        for (int k = 0; k < nb; k++) mm[s.addr + k] = s.wdata[8*k +: 8];
        m_stores = m_stores + 1;
      end
    end else begin
      e.data  = s.alu;
      e.rd_we = s.rd_we;
    end
  endtask

  // One clock cycle: drive at negedge, check against model, advance model.
  task automatic cycle(input stim_t s, input logic rdy, input logic r);
    res_t e;
    logic exp_ready;
    @(negedge clk);
    rst               = r;
    bus.in_valid      = s.valid;
    bus.in_op         = s.op;
    bus.in_size       = s.size;
    bus.in_unsigned   = s.uns;
    bus.in_addr       = s.addr;
    bus.in_wdata      = s.wdata;
    bus.in_alu_result = s.alu;
    bus.in_rd         = s.rd;
    bus.in_rd_we      = s.rd_we;
    bus.out_ready     = rdy;
    #1;
    exp_ready = !r && (q.size() == 0 || rdy);
    check("in_ready", bus.in_ready, exp_ready);
    check("out_valid", bus.out_valid, q.size() != 0);
    check("load_count", bus.load_count, m_loads);
    check("store_count", bus.store_count, m_stores);
    if (q.size() != 0) begin
      e = q[0];
      check("out_rd", bus.out_rd, e.rd);
      check("out_rd_we", bus.out_rd_we, e.rd_we);
      check("out_data", bus.out_data, e.data);
      check("out_fault", bus.out_fault, e.fault);
      check("out_cause", bus.out_fault_cause, e.cause);
    end
    if (r) begin
      q.delete();
      m_loads  = 0;
      m_stores = 0;
    end else begin
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (s.valid && exp_ready) begin
        model_exec(s, e);
        q.push_back(e);
      end
    end
    @(posedge clk);
  endtask

  function automatic stim_t mk(input logic [1:0] op, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] alu, input logic [4:0] rd, input logic rd_we);
    stim_t s;
    s.valid = 1'b1; s.op = op; s.size = size; s.uns = uns; s.addr = addr;
    s.wdata = wdata; s.alu = alu; s.rd = rd; s.rd_we = rd_we;
    return s;
  endfunction

  // Directed check of the freshly registered result, just after the edge.
  task automatic expect_now(input string tag, input logic [31:0] data, input logic we,
                            input logic [1:0] cause);
    #1;
    check({tag, "_valid"}, bus.out_valid, 1);
    check({tag, "_data"}, bus.out_data, data);
    check({tag, "_rd_we"}, bus.out_rd_we, we);
    check({tag, "_cause"}, bus.out_fault_cause, cause);
  endtask

  task automatic rand_stim(output stim_t s);
    s.valid = ($urandom_range(0, 3) != 0);
    s.op    = 2'($urandom_range(0, 3));
    s.size  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    s.uns   = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 9))
      0:       s.addr = $urandom;
      1:       s.addr = 32'($urandom_range(0, 2047));
      default: begin
        s.addr = 32'($urandom_range(0, 1023));
        if (s.size == 2'd1) s.addr[0] = 1'b0;
        else if (s.size == 2'd2) s.addr[1:0] = 2'b00;
      end
    endcase
    s.wdata = $urandom;
    s.alu   = $urandom;
    s.rd    = 5'($urandom_range(0, 31));
    s.rd_we = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t idle;
    stim_t s;
    idle = '0;
    for (int i = 0; i < DEPTH * 4; i++) mm[i] = 8'h00;

    // reset state
    cycle(idle, 1'b1, 1'b1);
    cycle(idle, 1'b1, 1'b1);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_load_count", bus.load_count, 0);
    check("rst_store_count", bus.store_count, 0);

    // bring RAM to a known all-zero image, then clear counters again
    for (int w = 0; w < DEPTH; w++) cycle(mk(2'd2, 2'd2, 1'b0, 32'(w * 4), 0, 0, 0, 0), 1'b1, 1'b0);
    cycle(idle, 1'b1, 1'b1);

    // word store then load
    cycle(mk(2'd2, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, 5'd1, 1'b1), 1'b1, 1'b0);
    expect_now("st_word", 32'h0, 1'b0, 2'd0);
    cycle(mk(2'd1, 2'd2, 1'b0, 32'h10, 0, 0, 5'd3, 1'b1), 1'b1, 1'b0);
    expect_now("ld_word", 32'hDEADBEEF, 1'b1, 2'd0);
    check("ld_word_rd", bus.out_rd, 3);
    cycle(idle, 1'b1, 1'b0);
    #1;
    check("cnt_load_1", bus.load_count, 1);
    check("cnt_store_1", bus.store_count, 1);

    // byte store and sign/zero-extended loads
    cycle(mk(2'd2, 2'd0, 1'b0, 32'h05, 32'h12345680, 0, 0, 1'b1), 1'b1, 1'b0);
    cycle(mk(2'd1, 2'd0, 1'b0, 32'h05, 0, 0, 5'd4, 1'b1), 1'b1, 1'b0);
    expect_now("ldb_s", 32'hFFFFFF80, 1'b1, 2'd0);
    cycle(mk(2'd1, 2'd0, 1'b1, 32'h05, 0, 0, 5'd4, 1'b1), 1'b1, 1'b0);
    expect_now("ldb_u", 32'h00000080, 1'b1, 2'd0);
    cycle(mk(2'd1, 2'd2, 1'b0, 32'h04, 0, 0, 5'd4, 1'b1), 1'b1, 1'b0);
    expect_now("ldw_4", 32'h00008000, 1'b1, 2'd0);

    // faults
    cycle(mk(2'd1, 2'd2, 1'b0, 32'h06, 0, 0, 5'd7, 1'b1), 1'b1, 1'b0);
    expect_now("f_align", 32'h0, 1'b0, 2'd1);
    cycle(mk(2'd2, 2'd1, 1'b0, 32'h400, 32'hFFFF, 0, 0, 1'b0), 1'b1, 1'b0);
    expect_now("f_range", 32'h0, 1'b0, 2'd2);
    cycle(mk(2'd1, 2'd2, 1'b0, 32'h0, 0, 0, 5'd7, 1'b1), 1'b1, 1'b0);
    expect_now("ram0", 32'h0, 1'b1, 2'd0);
    cycle(mk(2'd1, 2'd3, 1'b0, 32'h10, 0, 0, 5'd7, 1'b1), 1'b1, 1'b0);
    expect_now("f_size", 32'h0, 1'b0, 2'd3);

    // backpressure: 3 stalled cycles with a pending op, then drain+accept
    cycle(mk(2'd1, 2'd2, 1'b0, 32'h10, 0, 0, 5'd5, 1'b1), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(mk(2'd0, 2'd0, 1'b0, 0, 0, 32'h55, 5'd6, 1'b1), 1'b0, 1'b0);
      expect_now("stall_hold", 32'hDEADBEEF, 1'b1, 2'd0);
    end
    cycle(mk(2'd0, 2'd0, 1'b0, 0, 0, 32'h55, 5'd6, 1'b1), 1'b1, 1'b0);
    expect_now("drain_acc", 32'h55, 1'b1, 2'd0);
    for (int i = 0; i < 4; i++) cycle(mk(2'd1, 2'd1, 1'b1, 32'(i * 2), 0, 0, 5'(i), 1'b1), 1'b1, 1'b0);

    // pass op
    cycle(mk(2'd0, 2'd3, 1'b0, 32'h0, 0, 32'h12, 5'd2, 1'b1), 1'b1, 1'b0);
    expect_now("pass", 32'h12, 1'b1, 2'd0);
    check("pass_rd", bus.out_rd, 2);

    // reset during a stall, with a store presented under reset
    cycle(mk(2'd1, 2'd2, 1'b0, 32'h10, 0, 0, 5'd9, 1'b1), 1'b1, 1'b0);
    cycle(idle, 1'b0, 1'b0);
    cycle(mk(2'd2, 2'd2, 1'b0, 32'h10, 32'h11111111, 0, 0, 1'b0), 1'b0, 1'b1);
    #1;
    check("rst_stall_valid", bus.out_valid, 0);
    check("rst_stall_lcnt", bus.load_count, 0);
    check("rst_stall_scnt", bus.store_count, 0);
    cycle(idle, 1'b1, 1'b0);
    cycle(mk(2'd1, 2'd2, 1'b0, 32'h10, 0, 0, 5'd9, 1'b1), 1'b1, 1'b0);
    expect_now("rst_nowrite", 32'hDEADBEEF, 1'b1, 2'd0);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rand_stim(s);
      cycle(s, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 199) == 0));
    end
    cycle(idle, 1'b1, 1'b0);
    cycle(idle, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
